// File: rtl/warp_slot_executor.sv
// warp_slot_executor
//   Receiving end of the warp scheduler's launch interface. Accepted warps
//   occupy one of NUM_SLOTS execution slots; resident warps issue their
//   instruction fetches round-robin, and each warp's ID is returned on
//   finished_warp_id once its last instruction has issued.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   valid_kernel        a warp is offered this cycle
//   kernel_warp_id      ID of the offered warp (all-ones = "no warp", dropped)
//   kernel_num_threads  thread count of the offered warp
//   kernel_pc           starting PC of the offered warp
//   kernel_ready        a slot is free (accept = valid_kernel && kernel_ready)
//   issue_stall         fetch stage cannot take an issue this cycle
//   issue_valid         registered: issue presented this cycle
//   issue_warp_id       registered: warp ID of the issue
//   issue_pc            registered: PC of the issue
//   finished_warp_id    registered: retired warp ID, all-ones when none
//   drop_err            registered: pulse when an all-ones ID is discarded
module warp_slot_executor #(
  parameter int unsigned NUM_SLOTS         = 4,
  parameter int unsigned LOG2_THREAD_COUNT = 3,
  parameter int unsigned WARP_ID_W         = 4,
  parameter int unsigned INSTR_PER_THREAD  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_kernel,
  input  logic [WARP_ID_W-1:0]         kernel_warp_id,
  input  logic [LOG2_THREAD_COUNT-1:0] kernel_num_threads,
  input  logic [31:0]                  kernel_pc,
  output logic                         kernel_ready,
  input  logic                         issue_stall,
  output logic                         issue_valid,
  output logic [WARP_ID_W-1:0]         issue_warp_id,
  output logic [31:0]                  issue_pc,
  output logic [WARP_ID_W-1:0]         finished_warp_id,
  output logic                         drop_err
);

  localparam int unsigned IDXW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned CW   = LOG2_THREAD_COUNT + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } slot_state_t;

  slot_state_t            state_q [NUM_SLOTS];
  slot_state_t            state_d [NUM_SLOTS];
  logic [WARP_ID_W-1:0]   id_q    [NUM_SLOTS];
  logic [31:0]            pc_q    [NUM_SLOTS];
  logic [CW-1:0]          cnt_q   [NUM_SLOTS];
  logic [IDXW-1:0]        rr_q;

  logic                   accept_hit, issue_hit, retire_hit;
  logic [IDXW-1:0]        accept_sel, issue_sel, retire_sel;
  logic                   take, id_is_null, do_accept, do_issue;
  logic [CW-1:0]          init_cnt;

  // Slot selection: lowest IDLE for accept, lowest DONE for retire,
  // first RUN at or after rr (wrapping) for issue.
  always_comb begin
    int unsigned idx;
    accept_hit = 1'b0;
    accept_sel = '0;
    retire_hit = 1'b0;
    retire_sel = '0;
    issue_hit  = 1'b0;
    issue_sel  = '0;
    idx        = 0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!accept_hit && state_q[IDXW'(i)] == S_IDLE) begin
        accept_hit = 1'b1;
        accept_sel = IDXW'(i);
      end
      if (!retire_hit && state_q[IDXW'(i)] == S_DONE) begin
        retire_hit = 1'b1;
        retire_sel = IDXW'(i);
      end
      idx = (32'(rr_q) + i) % NUM_SLOTS;
      if (!issue_hit && state_q[IDXW'(idx)] == S_RUN) begin
        issue_hit = 1'b1;
        issue_sel = IDXW'(idx);
      end
    end
  end

  assign kernel_ready = accept_hit;
  assign take         = valid_kernel && kernel_ready;
  assign id_is_null   = (kernel_warp_id == '1);
  assign do_accept    = take && !id_is_null;
  assign do_issue     = issue_hit && !issue_stall;

  always_comb begin
    init_cnt = CW'(kernel_num_threads) * CW'(INSTR_PER_THREAD);
    if (kernel_num_threads == '0) begin
      init_cnt = CW'(1);
    end
  end

  // Accept, issue and retire always target slots in different states,
  // so the three updates never collide on one slot.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      state_d[i] = state_q[i];
    end
    if (do_accept) begin
      state_d[accept_sel] = S_RUN;
    end
    if (do_issue && cnt_q[issue_sel] == CW'(1)) begin
      state_d[issue_sel] = S_DONE;
    end
    if (retire_hit) begin
      state_d[retire_sel] = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      state_q[i] <= rst ? S_IDLE : state_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        id_q[i]  <= '0;
        pc_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      rr_q             <= '0;
      issue_valid      <= 1'b0;
      issue_warp_id    <= '0;
      issue_pc         <= '0;
      finished_warp_id <= '1;
      drop_err         <= 1'b0;
    end else begin
      drop_err <= take && id_is_null;

      if (do_accept) begin
        id_q[accept_sel]  <= kernel_warp_id;
        pc_q[accept_sel]  <= kernel_pc;
        cnt_q[accept_sel] <= init_cnt;
      end

      if (do_issue) begin
        issue_valid      <= 1'b1;
        issue_warp_id    <= id_q[issue_sel];
        issue_pc         <= pc_q[issue_sel];
        pc_q[issue_sel]  <= pc_q[issue_sel] + 32'd4;
        cnt_q[issue_sel] <= cnt_q[issue_sel] - CW'(1);
        rr_q             <= (issue_sel == IDXW'(NUM_SLOTS - 1)) ? '0 : issue_sel + IDXW'(1);
      end else begin
        issue_valid <= 1'b0;
      end

      finished_warp_id <= retire_hit ? id_q[retire_sel] : '1;
    end
  end

endmodule
